ext_pipe: RTL and testbench
===========================

EXT_PIPE -- requirements
Module: ext_pipe

Interface
REQ-001 Parameter IN_W, default 16, width of unextended input field (1..OUT_W).
REQ-002 Parameter OUT_W, default 32, width of extended output word.
REQ-003 Parameter CNT_W, default 16, width of transfer counter.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 IN_VALID  input  1  producer offers UNEXT/MODE this cycle.
REQ-007 IN_READY  output  1  block can accept a word this cycle.
REQ-008 UNEXT  input  IN_W  unextended field.
REQ-009 MODE  input  2  extension mode (ZERO=0, SIGN=1, UPPER=2, SHAMT=3).
REQ-010 EXT  output  OUT_W  extended word at head of buffer.
REQ-011 OUT_VALID  output  1  EXT holds a valid word.
REQ-012 OUT_READY  input  1  consumer takes EXT this cycle.
REQ-013 XFER_CNT  output  CNT_W  count of completed output transfers.

Function
REQ-014 Input transfer occurs on a cycle with IN_VALID && IN_READY; output transfer on OUT_VALID && OUT_READY.
REQ-015 Extension is computed on the input side and stored; buffer holds extended words, not raw fields.
REQ-016 ZERO: EXT = UNEXT zero-extended to OUT_W.
REQ-017 SIGN: EXT = UNEXT replicating bit IN_W-1 into upper OUT_W-IN_W bits.
REQ-018 UPPER: UNEXT placed in EXT[OUT_W-1:OUT_W-IN_W], lower bits zero.
REQ-019 SHAMT: EXT = UNEXT[4:0] zero-extended, bits IN_W-1..5 ignored; when IN_W<5, zero-extend UNEXT.
REQ-020 When IN_W == OUT_W, all modes except SHAMT yield EXT = UNEXT.
REQ-021 Buffer is a 2-entry in-order elastic (skid) buffer; states EMPTY, ONE, FULL.
REQ-022 EMPTY: push -> ONE; no push -> EMPTY.
REQ-023 ONE: push only -> FULL; pop only -> EMPTY; push and pop same cycle -> ONE.
REQ-024 FULL: pop -> ONE; no pop -> FULL; no push possible.
REQ-025 IN_READY = 1 in EMPTY and ONE, 0 in FULL; IN_READY depends only on state, never combinationally on OUT_READY.
REQ-026 OUT_VALID = 1 in ONE and FULL, 0 in EMPTY.
REQ-027 Latency: word accepted at edge N appears on EXT with OUT_VALID=1 from edge N onward (visible cycle N+1) when buffer was EMPTY.
REQ-028 Full-rate streaming (push+pop every cycle) sustains one word per cycle with no bubbles.
REQ-029 EXT and OUT_VALID stable while OUT_VALID && !OUT_READY.
REQ-030 Words exit in acceptance order; no word duplicated or dropped.
REQ-031 XFER_CNT increments by 1 per output transfer, wraps from all-ones to 0 without flag.
REQ-032 UNEXT/MODE are don't-care when IN_VALID=0 or IN_READY=0.

Reset
REQ-033 On a CLK edge with RST=1: state EMPTY, OUT_VALID 0, EXT 0, XFER_CNT 0, both buffer entries cleared; IN_READY reads 1 in the following cycle.
REQ-034 RST mid-operation discards buffered words; input offered in the RST cycle is not accepted; no pre-reset word ever appears on EXT.

Structure
REQ-035 Shared package ext_pkg holds MODE encodings and buffer state encodings; reused by decode logic.
REQ-036 Combinational extension is a sub-module ext_core (IN_W, OUT_W, UNEXT, MODE -> EXT), instantiated once at the input side of ext_pipe.

Verification (IN_W=16, OUT_W=32, CNT_W=16)
REQ-037 Push SIGN 16'h8001, OUT_READY=1 -> next cycle OUT_VALID=1, EXT=32'hFFFF8001; ZERO same value -> 32'h00008001.
REQ-038 Push UPPER 16'h1234 -> 32'h12340000; SHAMT 16'hFFFF -> 32'h0000001F.
REQ-039 OUT_READY=0, offer A,B,C on consecutive cycles -> A,B accepted, IN_READY=0 after B, EXT=A held stable; raise OUT_READY -> A,B,C out in order, C accepted once IN_READY returns to 1.
REQ-040 Stream 100 words with IN_VALID=OUT_READY=1 -> 100 consecutive output cycles, no bubbles, XFER_CNT=100.
REQ-041 Fill to FULL, assert RST one cycle -> OUT_VALID=0, EXT=0, XFER_CNT=0, IN_READY=1 next cycle, neither stale word emitted.
REQ-042 Preload path to XFER_CNT=16'hFFFF via 65535 transfers, one more transfer -> XFER_CNT=16'h0000.

Source files
------------

// File: rtl/ext_pkg.sv
// ext_pkg: shared encodings for the extension pipe.
//   ext_mode_e  - MODE input encoding used by the extension decode
//   buf_state_e - occupancy state of the 2-entry elastic buffer
package ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO  = 2'd0,
    MODE_SIGN  = 2'd1,
    MODE_UPPER = 2'd2,
    MODE_SHAMT = 2'd3
  } ext_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  localparam int BUF_DEPTH = 2;
  localparam int SHAMT_W   = 5;

endpackage

// File: rtl/ext_core.sv
// ext_core: combinational field extension.
//   UNEXT [IN_W]  - raw field
//   MODE  [2]     - ext_mode_e encoding
//   EXT   [OUT_W] - extended word
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  UNEXT,
  input  logic [1:0]       MODE,
  output logic [OUT_W-1:0] EXT
);

  // Shift amounts keep only the low 5 bits; narrower fields are taken whole.
  localparam int SH_W = (IN_W < SHAMT_W) ? IN_W : SHAMT_W;

  always_comb begin
    EXT = '0;
    case (ext_mode_e'(MODE))
      MODE_ZERO:  EXT[IN_W-1:0] = UNEXT;
      MODE_SIGN: begin
        EXT           = {OUT_W{UNEXT[IN_W-1]}};
        EXT[IN_W-1:0] = UNEXT;
      end
      MODE_UPPER: EXT[OUT_W-1 -: IN_W] = UNEXT;
      MODE_SHAMT: EXT[SH_W-1:0] = UNEXT[SH_W-1:0];
      default:    EXT = '0;
    endcase
  end

endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: extends incoming fields and queues the results in a 2-entry
// in-order skid buffer with valid/ready handshakes on both sides.
//   CLK, RST              - clock, synchronous active-high reset
//   IN_VALID/IN_READY     - input handshake for UNEXT/MODE
//   UNEXT [IN_W], MODE[2] - raw field and extension mode
//   EXT [OUT_W]           - head-of-buffer extended word
//   OUT_VALID/OUT_READY   - output handshake for EXT
//   XFER_CNT [CNT_W]      - wrapping count of output transfers
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [IN_W-1:0]  UNEXT,
  input  logic [1:0]       MODE,
  output logic [OUT_W-1:0] EXT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [CNT_W-1:0] XFER_CNT
);

  buf_state_e                         state_q, state_d;
  logic [BUF_DEPTH-1:0][OUT_W-1:0]    ent_q, ent_d;   // [0] is head
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [OUT_W-1:0]                   ext_w;
  logic                               push, pop;

  // Extension happens before storage so the buffer holds final words.
  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .UNEXT (UNEXT),
    .MODE  (MODE),
    .EXT   (ext_w)
  );

  // Ready is a pure function of state: no combinational path from OUT_READY.
  assign IN_READY  = (state_q != ST_FULL);
  assign OUT_VALID = (state_q != ST_EMPTY);
  assign EXT       = ent_q[0];
  assign XFER_CNT  = cnt_q;

  assign push = IN_VALID && IN_READY;
  assign pop  = OUT_VALID && OUT_READY;

  always_comb begin
    state_d = state_q;
    ent_d   = ent_q;
    cnt_d   = cnt_q + CNT_W'(pop);
    case (state_q)
      ST_EMPTY: if (push) begin
        ent_d[0] = ext_w;
        state_d  = ST_ONE;
      end
      ST_ONE: case ({push, pop})
        2'b10: begin ent_d[1] = ext_w; state_d = ST_FULL;  end
        2'b01: state_d = ST_EMPTY;
        2'b11: ent_d[0] = ext_w;   // replace head, stay ONE
        default: ;
      endcase
      ST_FULL: if (pop) begin
        ent_d[0] = ent_q[1];
        state_d  = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      ent_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
module tb_ext_pipe;
  import ext_pkg::*;

  logic        CLK = 1'b0;
  logic        RST, IN_VALID, IN_READY, OUT_VALID, OUT_READY;
  logic [15:0] UNEXT, XFER_CNT;
  logic [1:0]  MODE;
  logic [31:0] EXT;

  int n_cmp = 0;
  int n_err = 0;

  ext_pipe #(.IN_W(16), .OUT_W(32), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .UNEXT(UNEXT), .MODE(MODE), .EXT(EXT), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .XFER_CNT(XFER_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic v, input ext_mode_e m, input logic [15:0] d);
    IN_VALID = v;
    MODE     = m;
    UNEXT    = d;
  endtask

  initial begin
    int vld_cyc, bad;
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; UNEXT = '0; MODE = '0;
    step();
    RST = 1'b0;
    chk("rst_in_ready",  IN_READY, 1);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_ext",       EXT, 0);
    chk("rst_cnt",       XFER_CNT, 0);

    // Extension modes, streaming one per cycle.
    OUT_READY = 1'b1;
    offer(1, MODE_SIGN, 16'h8001);  step();
    chk("sign_valid", OUT_VALID, 1);
    chk("sign_ext",   EXT, 32'hFFFF8001);
    offer(1, MODE_ZERO, 16'h8001);  step();
    chk("zero_ext",   EXT, 32'h00008001);
    chk("zero_cnt",   XFER_CNT, 1);
    offer(1, MODE_UPPER, 16'h1234); step();
    chk("upper_ext",  EXT, 32'h12340000);
    offer(1, MODE_SHAMT, 16'hFFFF); step();
    chk("shamt_ext",  EXT, 32'h0000001F);
    offer(0, MODE_ZERO, 16'h0);     step();
    chk("drain_valid", OUT_VALID, 0);
    chk("drain_cnt",   XFER_CNT, 4);

    // Backpressure: A,B fill the buffer, C waits.
    OUT_READY = 1'b0;
    offer(1, MODE_ZERO, 16'h000A); step();
    chk("bp_a_ext", EXT, 32'hA);
    chk("bp_a_rdy", IN_READY, 1);
    offer(1, MODE_ZERO, 16'h000B); step();
    chk("bp_full_rdy", IN_READY, 0);
    chk("bp_full_ext", EXT, 32'hA);
    offer(1, MODE_ZERO, 16'h000C); step();
    chk("bp_hold_ext", EXT, 32'hA);
    chk("bp_hold_vld", OUT_VALID, 1);
    chk("bp_hold_cnt", XFER_CNT, 4);
    OUT_READY = 1'b1; step();
    chk("bp_b_ext", EXT, 32'hB);
    chk("bp_b_rdy", IN_READY, 1);
    step();
    chk("bp_c_ext", EXT, 32'hC);
    offer(0, MODE_ZERO, 16'h0); step();
    chk("bp_empty", OUT_VALID, 0);
    chk("bp_cnt",   XFER_CNT, 7);

    // Reset while FULL, with a word offered in the reset cycle.
    OUT_READY = 1'b0;
    offer(1, MODE_ZERO, 16'h00D0); step();
    offer(1, MODE_ZERO, 16'h00E0); step();
    chk("pre_rst_full", IN_READY, 0);
    RST = 1'b1;
    offer(1, MODE_ZERO, 16'h00F0); step();
    RST = 1'b0;
    offer(0, MODE_ZERO, 16'h0);
    chk("mid_rst_vld", OUT_VALID, 0);
    chk("mid_rst_ext", EXT, 0);
    chk("mid_rst_cnt", XFER_CNT, 0);
    chk("mid_rst_rdy", IN_READY, 1);
    OUT_READY = 1'b1;
    vld_cyc = 0;
    for (int i = 0; i < 4; i++) begin step(); if (OUT_VALID) vld_cyc++; end
    chk("no_stale", vld_cyc, 0);
    chk("no_stale_cnt", XFER_CNT, 0);

    // 100-word full-rate stream.
    vld_cyc = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      offer(1, MODE_ZERO, 16'(i + 16'h100));
      step();
      if (OUT_VALID) vld_cyc++;
      if (EXT !== 32'(i + 16'h100)) bad++;
    end
    offer(0, MODE_ZERO, 16'h0); step();
    chk("stream_valid_cycles", vld_cyc, 100);
    chk("stream_data_errs",    bad, 0);
    chk("stream_cnt",          XFER_CNT, 100);
    chk("stream_empty",        OUT_VALID, 0);

    // Counter wrap: 65536 push edges give 65535 output transfers.
    RST = 1'b1; step(); RST = 1'b0;
    offer(1, MODE_ZERO, 16'h5);
    OUT_READY = 1'b1;
    repeat (65536) step();
    chk("cnt_max",  XFER_CNT, 16'hFFFF);
    step();
    chk("cnt_wrap", XFER_CNT, 16'h0000);
    step();
    chk("cnt_after_wrap", XFER_CNT, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
